// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant among NUM_REQ producers, registered write port,
// x0 write drop and saturating contention counter. Define REGFILE_WB_FIXED_PRIO_EN for fixed priority.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*5-1:0]     req_rd,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     w_en,
  output logic [4:0]               rd_addr,
  output logic [WIDTH-1:0]         w_data,
  output logic [CNT_W-1:0]         conflict_cnt
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][4:0]       rd_v;
  logic [NUM_REQ-1:0][WIDTH-1:0] data_v;
  assign rd_v   = req_rd;
  assign data_v = req_data;

  logic [IW-1:0] ptr, gnt_idx;
  logic          found;

`ifdef REGFILE_WB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (found)
      ptr_d = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= '0;
    else        ptr_d_apply: ptr_q <= ptr_d;
`endif

  // First valid requester at or after ptr, wrapping; depends only on req_valid and ptr.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[IW'((int'(ptr) + k) % NUM_REQ)]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
    if (found && reset) req_ready[gnt_idx] = 1'b1;
  end

  logic             w_en_q, w_en_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] w_data_q, w_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             multi;

  assign multi = $countones(req_valid) > 1;

  always_comb begin
    w_en_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    w_data_d  = w_data_q;
    cnt_d     = cnt_q;
    if (found) begin
      // x0 still completes the handshake; only the write enable is suppressed.
      w_en_d    = rd_v[gnt_idx] != 5'd0;
      rd_addr_d = rd_v[gnt_idx];
      w_data_d  = data_v[gnt_idx];
    end
    if (multi && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_en_q    <= 1'b0;
      rd_addr_q <= '0;
      w_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      w_data_q  <= w_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign w_en         = w_en_q;
  assign rd_addr      = rd_addr_q;
  assign w_data       = w_data_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle compare against a behavioural model plus literal checks.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int CW = 4;
`ifdef REGFILE_WB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*5-1:0]   req_rd;
  logic [N*W-1:0]   req_data;
  logic             w_en;
  logic [4:0]       rd_addr;
  logic [W-1:0]     w_data;
  logic [CW-1:0]    conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .w_en(w_en), .rd_addr(rd_addr), .w_data(w_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Model: pointer, write-port contents and counter as plain integers.
  int           m_ptr  = 0;
  bit           m_wen  = 1'b0;
  logic [4:0]   m_rd   = '0;
  logic [W-1:0] m_data = '0;
  int           m_cnt  = 0;
  logic [N-1:0] m_g;
  logic [N-1:0] last_gnt;

  function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p);
    logic [N-1:0] one;
    one = 1;
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return one << ((p + k) % N);
    return '0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr = 0; m_wen = 1'b0; m_rd = '0; m_data = '0; m_cnt = 0;
    end else begin
      m_g   = exp_grant(req_valid, m_ptr);
      m_wen = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_g[i]) begin
          m_rd   = req_rd[5*i +: 5];
          m_data = req_data[W*i +: W];
          m_wen  = (m_rd != 0);
          if (!FIXED) m_ptr = (i + 1) % N;
        end
      end
      if ($countones(req_valid) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    last_gnt = req_ready;
    chk("m_req_ready", 32'(req_ready), reset ? 32'(exp_grant(req_valid, m_ptr)) : 32'd0);
    chk("m_w_en", 32'(w_en), 32'(m_wen));
    chk("m_rd_addr", 32'(rd_addr), 32'(m_rd));
    chk("m_w_data", w_data, m_data);
    chk("m_conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] rd, input logic [W-1:0] d);
    req_valid[i]       = v;
    req_rd[5*i +: 5]   = rd;
    req_data[W*i +: W] = d;
  endtask

  initial begin
    int rr_g[5];
    int fx_g[3];
    reset = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
    set_req(0, 1, 1, 32'h11); set_req(1, 1, 2, 32'h22); set_req(2, 1, 3, 32'h33);
    if (FIXED) begin
      rr_g = '{1, 1, 1, 1, 1}; fx_g = '{1, 1, 1};
    end else begin
      rr_g = '{1, 2, 4, 1, 2}; fx_g = '{4, 1, 2};
    end

    // Reset held with every requester valid
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);
    cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("first_gnt", 32'(req_ready), 1);

    // All valid: round-robin grants and write-port contents one cycle later
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("rr_gnt", 32'(last_gnt), 32'(rr_g[c]));
      if (c < 3) begin
        chk("rr_w_en", 32'(w_en), 1);
        chk("rr_rd", 32'(rd_addr), FIXED ? 32'd1 : 32'(c + 1));
        chk("rr_data", w_data, FIXED ? 32'h11 : 32'h11 * 32'(c + 1));
      end
    end
    chk("rr_cnt", 32'(conflict_cnt), 5);

    // x0 drop: handshake completes, no write
    req_valid = '0;
    set_req(1, 1, 0, 32'd400);
    cyc();
    chk("x0_gnt", 32'(last_gnt), 2);
    chk("x0_w_en", 32'(w_en), 0);
    chk("x0_data", w_data, 32'd400);
    chk("x0_cnt", 32'(conflict_cnt), 5);

    // Pointer hold across idle cycles
    req_valid = '0;
    set_req(2, 1, 3, 32'h33);
    cyc();
    chk("ph_gnt2", 32'(last_gnt), 4);
    chk("ph_rd", 32'(rd_addr), 3);
    req_valid = '0;
    repeat (3) cyc();
    chk("ph_idle_w_en", 32'(w_en), 0);
    chk("ph_hold_rd", 32'(rd_addr), 3);
    chk("ph_hold_data", w_data, 32'h33);
    set_req(0, 1, 7, 32'h70); set_req(2, 1, 9, 32'h90);
    cyc();
    chk("ph_gnt0", 32'(last_gnt), 1);
    chk("ph_rd7", 32'(rd_addr), 7);
    chk("ph_cnt", 32'(conflict_cnt), 6);

    // Async reset while a write to x31 is on the port
    req_valid = '0;
    set_req(0, 1, 31, 32'hDEAD);
    cyc();
    chk("ar_w_en_before", 32'(w_en), 1);
    chk("ar_rd_before", 32'(rd_addr), 31);
    #2 reset = 1'b0;
    #1;
    chk("ar_w_en_now", 32'(w_en), 0);
    chk("ar_cnt_now", 32'(conflict_cnt), 0);
    chk("ar_ready_now", 32'(req_ready), 0);
    cyc();
    chk("ar_w_en_edge", 32'(w_en), 0);
    reset = 1'b1;
    req_valid = '0;
    set_req(1, 1, 5, 32'h55); set_req(2, 1, 6, 32'h66);
    cyc();
    chk("ar_regnt", 32'(last_gnt), 2);
    chk("ar_rd5", 32'(rd_addr), 5);

    // Counter saturation with two requesters valid
    req_valid = '0;
    set_req(0, 1, 1, 32'h1); set_req(1, 1, 2, 32'h2);
    repeat (20) cyc();
    chk("sat_cnt", 32'(conflict_cnt), 15);

    // All valid: fixed priority always picks req 0, round-robin rotates
    set_req(2, 1, 3, 32'h3);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("fx_gnt", 32'(last_gnt), 32'(fx_g[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
